i2c_slave_regfile: RTL and testbench

Parametrised I2C target with an addressable register bank, the next generation of the team's single-byte I2C receiver. Decodes START/repeated-START/STOP, matches a configurable 7-bit address, supports both write and read transfers of any length, and ACKs/NACKs per byte. Sits between the board-level open-drain SCL/SDA pins and fabric logic that consumes the register outputs (LEDs, control words).

---
 rtl/i2c_slave_regfile.sv | 181 ++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target with addressable register bank
// Optional pointer auto-increment: I2C_SLAVE_AUTOINC_EN
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h4C,
    parameter int         NUM_REGS   = 4,
    localparam int        PW         = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic                  wr_valid,
    output logic [PW-1:0]         wr_ptr,
    output logic                  busy
);

    localparam logic [8:0]    NREGS9   = 9'(NUM_REGS);
    localparam logic [PW-1:0] LAST_PTR = PW'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
    } state_t;

    state_t        state;
    logic          scl_m, scl_s, scl_d;
    logic          sda_m, sda_s, sda_d;
    logic          scl_rise, scl_fall, start_c, stop_c;
    logic [3:0]    cnt;
    logic [7:0]    shreg;
    logic          rw;
    logic          mack;
    logic          sda_oe;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_step;
    logic [7:0]    regs [NUM_REGS];

    // Synchronisers idle high so a released bus never produces a spurious edge after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_m <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
            sda_m <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_m <= scl;   scl_s <= scl_m; scl_d <= scl_s;
            sda_m <= sda;   sda_s <= sda_m; sda_d <= sda_s;
        end
    end

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

    assign ptr_inc = (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
`ifdef I2C_SLAVE_AUTOINC_EN
    assign ptr_step = ptr_inc;
`else
    assign ptr_step = ptr;
`endif

    assign sda = sda_oe ? 1'b0 : 1'bz;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[8*i +: 8] = regs[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            rw       <= 1'b0;
            mack     <= 1'b1;
            sda_oe   <= 1'b0;
            ptr      <= '0;
            wr_valid <= 1'b0;
            wr_ptr   <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (stop_c) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_c) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && cnt != 4'd8) begin
                            shreg <= {shreg[6:0], sda_s};
                            cnt   <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            cnt <= '0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == SLAVE_ADDR) begin
                                    rw     <= shreg[0];
                                    sda_oe <= 1'b1;
                                    state  <= ADDR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                if ({1'b0, shreg} < NREGS9) begin
                                    ptr    <= shreg[PW-1:0];
                                    sda_oe <= 1'b1;
                                    state  <= PTR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else begin
                                regs[ptr] <= shreg;
                                wr_valid  <= 1'b1;
                                wr_ptr    <= ptr;
                                ptr       <= ptr_step;
                                sda_oe    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            cnt <= '0;
                            if (rw) begin
                                shreg  <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt != 4'd0) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                cnt    <= '0;
                                state  <= RD_MACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    RD_MACK: begin
                        if (scl_rise) begin
                            mack <= sda_s;
                        end else if (scl_fall) begin
                            if (!mack) begin
                                ptr    <= ptr_step;
                                shreg  <= regs[ptr_step];
                                sda_oe <= ~regs[ptr_step][7];
                                state  <= RDATA;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - bus-level bench for i2c_slave_regfile
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

    localparam int NUM_REGS = 4;
    localparam int Q        = 100;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       aack;
        logic       pack;
        logic       dack;
    } vec_t;

    typedef struct packed {
        logic [1:0] p;
        logic [7:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    wire         sda;
    logic [31:0] reg_q;
    logic        wr_valid;
    logic [1:0]  wr_ptr;
    logic        busy;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  mregs [NUM_REGS];
    logic [1:0]  ptr_m = '0;
    wr_t         exp_q [$];
    vec_t        vecs  [8];

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h4C), .NUM_REGS(NUM_REGS)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (m_scl),
        .sda      (sda),
        .reg_q    (reg_q),
        .wr_valid (wr_valid),
        .wr_ptr   (wr_ptr),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_q();
        logic [31:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = mregs[i];
        return r;
    endfunction

    // Committed writes are matched against what the bench pushed before clocking each byte
    always @(negedge clk) begin
        if (wr_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_wr_valid: got ptr %0d data %h expected no write", wr_ptr, reg_q[int'(wr_ptr)*8 +: 8]);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_ptr", 32'(wr_ptr), 32'(e.p));
                check("wr_data", 32'(reg_q[int'(wr_ptr)*8 +: 8]), 32'(e.d));
            end
        end
    end

    task automatic bus_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q;
        m_scl = 1'b1; #(2*Q);
        m_scl = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        b = sda; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(~ack);
        m_sda = 1'b1;
    endtask

    task automatic wb(input string name, input logic [7:0] b, input logic exp_ack);
        logic ack;
        write_byte(b, ack);
        check(name, 32'(ack), 32'(exp_ack));
    endtask

    task automatic m_write(input logic [7:0] d);
        wr_t e;
        e.p = ptr_m;
        e.d = d;
        exp_q.push_back(e);
        mregs[ptr_m] = d;
`ifdef I2C_SLAVE_AUTOINC_EN
        ptr_m = ptr_m + 2'd1;
`endif
    endtask

    task automatic m_read_adv();
`ifdef I2C_SLAVE_AUTOINC_EN
        ptr_m = ptr_m + 2'd1;
`endif
    endtask

    initial begin
        logic [7:0] rd;

        vecs[0] = '{8'h98, 8'h01, 8'hA5, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{8'h98, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'h98, 8'h03, 8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'h98, 8'h02, 8'h5A, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'h90, 8'h55, 8'h77, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h98, 8'h07, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h98, 8'h04, 8'h34, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h98, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;

        repeat (4) @(posedge clk);
        #1;
        check("reset_reg_q", reg_q, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_wr_valid", 32'(wr_valid), 32'h0);
        check("reset_wr_ptr", 32'(wr_ptr), 32'h0);
        check("reset_sda", 32'(sda), 32'h1);
        reset = 1'b0;
        #(2*Q);

        for (int i = 0; i < 8; i++) begin
            bus_start();
            check("busy_after_start", 32'(busy), 32'h1);
            wb("addr_ack", vecs[i].addr, vecs[i].aack);
            wb("ptr_ack", vecs[i].ptr, vecs[i].pack);
            if (vecs[i].pack) ptr_m = vecs[i].ptr[1:0];
            if (vecs[i].dack) m_write(vecs[i].data);
            wb("data_ack", vecs[i].data, vecs[i].dack);
            bus_stop();
            #Q;
            check("busy_after_stop", 32'(busy), 32'h0);
            check("reg_q_vec", reg_q, model_q());
        end

        // Multi-byte burst from pointer 2
        bus_start();
        wb("burst_addr", 8'h98, 1'b1);
        wb("burst_ptr", 8'h02, 1'b1);
        ptr_m = 2'd2;
        m_write(8'h11); wb("burst_d0", 8'h11, 1'b1);
        m_write(8'h22); wb("burst_d1", 8'h22, 1'b1);
        m_write(8'h33); wb("burst_d2", 8'h33, 1'b1);
        bus_stop();
        #Q;
        check("burst_reg_q", reg_q, model_q());

        // Pointer write then repeated-START read, ACK then NACK
        bus_start();
        wb("rd_addr_w", 8'h98, 1'b1);
        wb("rd_ptr", 8'h01, 1'b1);
        ptr_m = 2'd1;
        bus_start();
        wb("rd_addr_r", 8'h99, 1'b1);
        read_byte(rd, 1'b1);
        check("rd_byte0", 32'(rd), 32'(mregs[ptr_m]));
        m_read_adv();
        read_byte(rd, 1'b0);
        check("rd_byte1", 32'(rd), 32'(mregs[ptr_m]));
        #Q;
        check("rd_sda_released", 32'(sda), 32'h1);
        check("rd_busy_wait_stop", 32'(busy), 32'h1);
        bus_stop();
        #Q;
        check("rd_busy_after_stop", 32'(busy), 32'h0);

        // Address mismatch: no drive, busy drops, data ignored
        bus_start();
        wb("mis_addr", 8'h90, 1'b0);
        #Q;
        check("mis_busy", 32'(busy), 32'h0);
        wb("mis_data", 8'h55, 1'b0);
        bus_stop();
        #Q;
        check("mis_reg_q", reg_q, model_q());

        // Out-of-range pointer: NACK, later bytes ignored, pointer kept
        bus_start();
        wb("bad_addr", 8'h98, 1'b1);
        wb("bad_ptr", 8'h07, 1'b0);
        wb("bad_data", 8'h12, 1'b0);
        bus_stop();
        #Q;
        check("bad_reg_q", reg_q, model_q());
        bus_start();
        wb("keep_addr_r", 8'h99, 1'b1);
        read_byte(rd, 1'b0);
        check("keep_ptr_read", 32'(rd), 32'(mregs[ptr_m]));
        bus_stop();
        #Q;

        // Reset during bit 4 of a data byte
        bus_start();
        wb("rst_addr", 8'h98, 1'b1);
        wb("rst_ptr", 8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #(Q/2);
        reset = 1'b1;
        #1;
        check("rst_sda", 32'(sda), 32'h1);
        check("rst_reg_q", reg_q, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
        ptr_m = '0;
        #Q;
        reset = 1'b0;
        #(2*Q);
        bus_start();
        wb("post_rst_addr", 8'h98, 1'b1);
        wb("post_rst_ptr", 8'h02, 1'b1);
        ptr_m = 2'd2;
        m_write(8'hC3);
        wb("post_rst_data", 8'hC3, 1'b1);
        bus_stop();
        #Q;
        check("post_rst_reg_q", reg_q, model_q());

        #Q;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
